inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter: IB_DEPTH, 8, number of entries (power of two, >=4).
REQ-002 SHALL have port: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: if_nValid  in  2  fetched insns offered this cycle, 0..2 (3 treated as 2).
REQ-005 SHALL have port: if_inst0, if_inst1  in  32 each  fetched insns; slot 0 is program-older.
REQ-006 SHALL have port: if_pc0, if_pc1  in  64 each  PCs of the fetched insns.
REQ-007 SHALL have port: haz_nDispatched  in  2  insns consumed by dispatch this cycle, 0..2.
REQ-008 SHALL have port: br_pred_wrong  in  1  mispredict flush.
REQ-009 SHALL have port: ib_nAccepted  out  2  fetched insns written this cycle.
REQ-010 SHALL have port: ib_nIsnBuffer  out  2  min(count, 2).
REQ-011 SHALL have port: ib_inst0, ib_inst1  out  32 each  oldest and second-oldest entries.
REQ-012 SHALL have port: ib_pc0, ib_pc1  out  64 each  PCs of those entries.
REQ-013 SHALL have port: ib_count  out  $clog2(IB_DEPTH)+1  occupied entries.
REQ-014 SHALL have port: ib_full  out  1  high when free entries < 2.
REQ-015 SHALL have port: ib_stallCycles  out  16  fetch-stall counter (see Configuration).

Function
REQ-016 SHALL operate as a circular FIFO with head/tail pointers wrapping modulo IB_DEPTH.
REQ-017 SHALL compute free = IB_DEPTH - ib_count from registered state only; same-cycle pops do not add space.
REQ-018 SHALL drive ib_nAccepted = min(if_nValid, free, 2) combinationally; 0 while br_pred_wrong.
REQ-019 SHALL, for ib_nAccepted = 1, write only slot 0; for 2, write slot 0 at tail and slot 1 at tail+1.
REQ-020 SHALL pop min(haz_nDispatched, ib_nIsnBuffer) entries from head each cycle; excess requests ignored.
REQ-021 SHALL update count next = count + accepted - popped when push and pop coincide.
REQ-022 SHALL drive ib_inst0/ib_pc0 from head and ib_inst1/ib_pc1 from head+1 combinationally; invalid positions drive zero.
REQ-023 SHALL, on br_pred_wrong, set head = tail = 0 and count = 0 at the next edge, ignoring pops and pushes that cycle.
REQ-024 SHALL keep ib_full and ib_nIsnBuffer derived from registered count (no input-to-output path).
REQ-025 SHALL never overwrite a valid entry and never pop an empty buffer.

Reset
REQ-026 SHALL, on reset low, immediately clear head, tail, count and ib_stallCycles to 0 regardless of clock.
REQ-027 SHALL, during reset, output ib_nAccepted = 0, ib_nIsnBuffer = 0, ib_count = 0, ib_full = 0, all insn/PC outputs 0.
REQ-028 SHALL resume normal operation on the first rising edge after reset deasserts; entry storage need not be cleared.

Configuration
REQ-029 SHALL, with IB_STALL_CNT_EN defined, increment ib_stallCycles each cycle where if_nValid > ib_nAccepted and br_pred_wrong is low, saturating at 16'hFFFF.
REQ-030 SHALL, without IB_STALL_CNT_EN, tie ib_stallCycles to 0 and synthesize no counter.

Verification
REQ-031 SHALL cover: reset, if_nValid=2 for 4 cycles, no dispatch -> count 8, ib_full=1, ib_nAccepted=0 on 5th cycle.
REQ-032 SHALL cover: count=7, if_nValid=2 -> ib_nAccepted=1, only if_inst0 stored, count 8.
REQ-033 SHALL cover: count=1, haz_nDispatched=2, if_nValid=2 -> popped 1, accepted 2, count 2, ib_inst0 = older fetched insn.
REQ-034 SHALL cover: head at entry 7, push 2, pop 2 repeatedly for 10 cycles -> ordering preserved across wrap, count constant.
REQ-035 SHALL cover: count=5, br_pred_wrong=1 with if_nValid=2 -> next cycle count 0, ib_nIsnBuffer 0, ib_nAccepted 0 during flush.
REQ-036 SHALL cover: with IB_STALL_CNT_EN, full buffer and if_nValid=2 for 3 cycles -> ib_stallCycles=3; reset low mid-operation -> all outputs 0 before next edge.

Source files
------------

// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Circular instruction buffer between fetch and dispatch. Fetch offers up to
//   two instructions per cycle (slot 0 is program-older). Dispatch consumes up
//   to two per cycle from the head. A mispredict flush empties the buffer.
//
//   Optional feature macro: IB_STALL_CNT_EN
//     defined   -> ib_stallCycles counts cycles in which fetch offered more
//                  instructions than were accepted (saturating, 16 bit)
//     undefined -> ib_stallCycles is tied to zero, no counter is built
//
// Ports
//   clock            in   sole clock, rising edge
//   reset            in   asynchronous, active-low reset
//   if_nValid        in   [1:0]  insns offered by fetch (3 behaves as 2)
//   if_inst0/1       in   [31:0] fetched insns, slot 0 older
//   if_pc0/1         in   [63:0] PCs of fetched insns
//   haz_nDispatched  in   [1:0]  insns consumed by dispatch
//   br_pred_wrong    in   mispredict flush
//   ib_nAccepted     out  [1:0]  fetched insns written this cycle
//   ib_nIsnBuffer    out  [1:0]  min(count, 2)
//   ib_inst0/1       out  [31:0] oldest / second-oldest entry (0 if invalid)
//   ib_pc0/1         out  [63:0] PCs of those entries (0 if invalid)
//   ib_count         out  occupied entries
//   ib_full          out  fewer than two free entries
//   ib_stallCycles   out  [15:0] fetch-stall counter
// -----------------------------------------------------------------------------
module inst_buffer #(
    parameter int IB_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    if_nValid,
    input  logic [31:0]                   if_inst0,
    input  logic [31:0]                   if_inst1,
    input  logic [63:0]                   if_pc0,
    input  logic [63:0]                   if_pc1,
    input  logic [1:0]                    haz_nDispatched,
    input  logic                          br_pred_wrong,
    output logic [1:0]                    ib_nAccepted,
    output logic [1:0]                    ib_nIsnBuffer,
    output logic [31:0]                   ib_inst0,
    output logic [31:0]                   ib_inst1,
    output logic [63:0]                   ib_pc0,
    output logic [63:0]                   ib_pc1,
    output logic [$clog2(IB_DEPTH):0]     ib_count,
    output logic                          ib_full,
    output logic [15:0]                   ib_stallCycles
);

    localparam int PW = $clog2(IB_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   inst_mem [IB_DEPTH];
    logic [63:0]   pc_mem   [IB_DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] head_p1, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;
    logic [1:0]    nv_eff;
    logic [1:0]    accepted;
    logic [1:0]    n_isn;
    logic [1:0]    popped;

    // Pointer arithmetic wraps for free because IB_DEPTH is a power of two.
    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;

    // Space is judged from registered occupancy only, so a same-cycle pop
    // never frees room for a push; this keeps fetch handshake off the
    // dispatch path.
    assign free   = CW'(IB_DEPTH) - count_q;
    assign nv_eff = (if_nValid == 2'd3) ? 2'd2 : if_nValid;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        accepted = nv_eff;
        if (free < CW'(nv_eff)) begin
            // free is 0 or 1 here, so its low two bits are exact
            accepted = free[1:0];
        end
        if (br_pred_wrong || !reset) begin
            accepted = 2'd0;
        end
    end

    assign n_isn  = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    assign popped = (haz_nDispatched > n_isn) ? n_isn : haz_nDispatched;

    always_comb begin
        head_d  = head_q + PW'(popped);
        tail_d  = tail_q + PW'(accepted);
        count_d = count_q + CW'(accepted) - CW'(popped);
        if (br_pred_wrong) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; outputs are masked by count, so stale
    // contents are never visible and the array can map onto plain RAM/flops.
    always_ff @(posedge clock) begin
        if (accepted != 2'd0) begin
            inst_mem[tail_q] <= if_inst0;
            pc_mem[tail_q]   <= if_pc0;
        end
        if (accepted == 2'd2) begin
            inst_mem[tail_p1] <= if_inst1;
            pc_mem[tail_p1]   <= if_pc1;
        end
    end

    assign ib_nAccepted  = accepted;
    assign ib_nIsnBuffer = n_isn;
    assign ib_count      = count_q;
    assign ib_full       = (free < CW'(2));

    assign ib_inst0 = (count_q != '0)        ? inst_mem[head_q]  : 32'd0;
    assign ib_pc0   = (count_q != '0)        ? pc_mem[head_q]    : 64'd0;
    assign ib_inst1 = (count_q >= CW'(2))    ? inst_mem[head_p1] : 32'd0;
    assign ib_pc1   = (count_q >= CW'(2))    ? pc_mem[head_p1]   : 64'd0;

`ifdef IB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!br_pred_wrong && (nv_eff > accepted) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign ib_stallCycles = stall_q;
`else
    assign ib_stallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Directed bench for inst_buffer (IB_DEPTH = 8). Fetched instruction n is
//   32'hA000_0000 + n with PC 64'h1000 + 4*n, so expected head contents are
//   written down directly by sequence number.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

    logic        clock;
    logic        reset;
    logic [1:0]  if_nValid;
    logic [31:0] if_inst0, if_inst1;
    logic [63:0] if_pc0, if_pc1;
    logic [1:0]  haz_nDispatched;
    logic        br_pred_wrong;
    logic [1:0]  ib_nAccepted;
    logic [1:0]  ib_nIsnBuffer;
    logic [31:0] ib_inst0, ib_inst1;
    logic [63:0] ib_pc0, ib_pc1;
    logic [3:0]  ib_count;
    logic        ib_full;
    logic [15:0] ib_stallCycles;

    int checks   = 0;
    int failures = 0;

    inst_buffer #(.IB_DEPTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .if_nValid       (if_nValid),
        .if_inst0        (if_inst0),
        .if_inst1        (if_inst1),
        .if_pc0          (if_pc0),
        .if_pc1          (if_pc1),
        .haz_nDispatched (haz_nDispatched),
        .br_pred_wrong   (br_pred_wrong),
        .ib_nAccepted    (ib_nAccepted),
        .ib_nIsnBuffer   (ib_nIsnBuffer),
        .ib_inst0        (ib_inst0),
        .ib_inst1        (ib_inst1),
        .ib_pc0          (ib_pc0),
        .ib_pc1          (ib_pc1),
        .ib_count        (ib_count),
        .ib_full         (ib_full),
        .ib_stallCycles  (ib_stallCycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef IB_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    function automatic logic [63:0] pcv(input int n);
        return 64'h1000 + 64'(4 * n);
    endfunction

    // Offer fetched insns n (slot 0) and n+1 (slot 1).
    task automatic fetch(input int n, input logic [1:0] nv);
        if_inst0  = ins(n);
        if_inst1  = ins(n + 1);
        if_pc0    = pcv(n);
        if_pc1    = pcv(n + 1);
        if_nValid = nv;
    endtask

    // Advance one rising edge and land 2 time units after it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        br_pred_wrong   = 1'b0;
        haz_nDispatched = 2'd0;
        fetch(0, 2'd2);
        #3;
        // Reset state, with fetch already offering insns
        check("rst_acc",   64'(ib_nAccepted),   64'd0);
        check("rst_count", 64'(ib_count),       64'd0);
        check("rst_full",  64'(ib_full),        64'd0);
        check("rst_nisn",  64'(ib_nIsnBuffer),  64'd0);
        check("rst_inst0", 64'(ib_inst0),       64'd0);
        check("rst_pc1",   ib_pc1,              64'd0);
        check("rst_stall", 64'(ib_stallCycles), 64'd0);
        #10;
        reset = 1'b1;

        // Fill: four cycles of two insns each, no dispatch
        for (int k = 0; k < 4; k++) begin
            fetch(2 * k, 2'd2);
            #1;
            check("fill_acc", 64'(ib_nAccepted), 64'd2);
            tick();
            check("fill_count", 64'(ib_count), 64'(2 * (k + 1)));
        end
        check("full_flag",  64'(ib_full),       64'd1);
        check("full_nisn",  64'(ib_nIsnBuffer), 64'd2);
        check("full_inst0", 64'(ib_inst0),      64'(ins(0)));
        check("full_inst1", 64'(ib_inst1),      64'(ins(1)));
        check("full_pc0",   ib_pc0,             pcv(0));
        check("full_pc1",   ib_pc1,             pcv(1));

        // Fetch keeps offering into a full buffer for three cycles
        fetch(8, 2'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_acc", 64'(ib_nAccepted), 64'd0);
            tick();
        end
        check("stall_cnt3",  64'(ib_stallCycles), STALL_EN ? 64'd3 : 64'd0);
        check("stall_count", 64'(ib_count),       64'd8);
        check("no_overwr",   64'(ib_inst0),       64'(ins(0)));

        // Pop one -> count 7, still full
        if_nValid       = 2'd0;
        haz_nDispatched = 2'd1;
        tick();
        check("c7_count", 64'(ib_count), 64'd7);
        check("c7_full",  64'(ib_full),  64'd1);
        check("c7_inst0", 64'(ib_inst0), 64'(ins(1)));

        // count 7, two offered -> only slot 0 (insn 8) taken
        haz_nDispatched = 2'd0;
        fetch(8, 2'd2);
        #1;
        check("c7_acc", 64'(ib_nAccepted), 64'd1);
        tick();
        check("c8_count", 64'(ib_count),       64'd8);
        check("c8_stall", 64'(ib_stallCycles), STALL_EN ? 64'd4 : 64'd0);

        // Drain two at a time: 1,2 / 3,4 / 5,6 / 7,8
        if_nValid       = 2'd0;
        haz_nDispatched = 2'd2;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("drain_inst0", 64'(ib_inst0), 64'(ins(1 + 2 * j)));
            check("drain_inst1", 64'(ib_inst1), 64'(ins(2 + 2 * j)));
            tick();
            if (j == 0) check("c6_full", 64'(ib_full), 64'd0);
        end
        check("empty_count", 64'(ib_count),      64'd0);
        check("empty_nisn",  64'(ib_nIsnBuffer), 64'd0);
        check("empty_inst0", 64'(ib_inst0),      64'd0);
        check("empty_pc0",   ib_pc0,             64'd0);
        tick();
        check("empty_pop", 64'(ib_count), 64'd0);

        // count 1, dispatch 2 and fetch 2 together
        haz_nDispatched = 2'd0;
        fetch(10, 2'd1);
        #1;
        check("one_acc", 64'(ib_nAccepted), 64'd1);
        tick();
        check("one_count", 64'(ib_count), 64'd1);
        haz_nDispatched = 2'd2;
        fetch(11, 2'd2);
        #1;
        check("mix_acc",   64'(ib_nAccepted),  64'd2);
        check("mix_nisn",  64'(ib_nIsnBuffer), 64'd1);
        check("mix_inst0", 64'(ib_inst0),      64'(ins(10)));
        check("mix_inst1", 64'(ib_inst1),      64'd0);
        tick();
        check("mix_count", 64'(ib_count), 64'd2);
        check("mix_new0",  64'(ib_inst0), 64'(ins(11)));
        check("mix_new1",  64'(ib_inst1), 64'(ins(12)));

        // Walk head to entry 7 (head 2 -> 4 -> 4 -> 4 -> 6 -> 7)
        haz_nDispatched = 2'd2; if_nValid = 2'd0; tick();
        haz_nDispatched = 2'd0; fetch(13, 2'd2);  tick();
        fetch(15, 2'd1);                          tick();
        haz_nDispatched = 2'd2; if_nValid = 2'd0; tick();
        haz_nDispatched = 2'd1; fetch(16, 2'd2);  tick();
        check("h7_count", 64'(ib_count), 64'd2);
        check("h7_inst0", 64'(ins(16)) ^ 64'(ib_inst0), 64'd0);
        check("h7_inst1", 64'(ib_inst1), 64'(ins(17)));

        // Steady push 2 / pop 2 across the wrap
        haz_nDispatched = 2'd2;
        for (int i = 0; i < 10; i++) begin
            fetch(18 + 2 * i, 2'd2);
            #1;
            check("wrap_acc",   64'(ib_nAccepted), 64'd2);
            check("wrap_inst0", 64'(ib_inst0),     64'(ins(16 + 2 * i)));
            check("wrap_inst1", 64'(ib_inst1),     64'(ins(17 + 2 * i)));
            check("wrap_pc1",   ib_pc1,            pcv(17 + 2 * i));
            tick();
            check("wrap_count", 64'(ib_count), 64'd2);
        end
        check("wrap_last", 64'(ib_inst0), 64'(ins(36)));

        // Build count 5, then flush with fetch and dispatch active
        haz_nDispatched = 2'd0;
        fetch(38, 2'd2); tick();
        fetch(40, 2'd1); tick();
        check("c5_count", 64'(ib_count), 64'd5);
        br_pred_wrong   = 1'b1;
        haz_nDispatched = 2'd2;
        fetch(41, 2'd2);
        #1;
        check("flush_acc", 64'(ib_nAccepted), 64'd0);
        tick();
        br_pred_wrong   = 1'b0;
        haz_nDispatched = 2'd0;
        check("flush_count", 64'(ib_count),       64'd0);
        check("flush_nisn",  64'(ib_nIsnBuffer),  64'd0);
        check("flush_inst0", 64'(ib_inst0),       64'd0);
        check("flush_stall", 64'(ib_stallCycles), STALL_EN ? 64'd4 : 64'd0);

        // Refill after flush
        fetch(41, 2'd2); tick();
        check("refill_inst0", 64'(ib_inst0), 64'(ins(41)));
        fetch(43, 2'd2); tick();
        fetch(45, 2'd2); tick();
        check("c6b_full", 64'(ib_full),       64'd0);
        check("c6b_nisn", 64'(ib_nIsnBuffer), 64'd2);
        fetch(47, 2'd2); tick();
        check("c8b_full", 64'(ib_full), 64'd1);

        // Asynchronous reset mid-operation, checked before any edge
        fetch(49, 2'd2);
        reset = 1'b0;
        #1;
        check("mrst_count", 64'(ib_count),       64'd0);
        check("mrst_full",  64'(ib_full),        64'd0);
        check("mrst_nisn",  64'(ib_nIsnBuffer),  64'd0);
        check("mrst_acc",   64'(ib_nAccepted),   64'd0);
        check("mrst_inst0", 64'(ib_inst0),       64'd0);
        check("mrst_inst1", 64'(ib_inst1),       64'd0);
        check("mrst_pc0",   ib_pc0,              64'd0);
        check("mrst_stall", 64'(ib_stallCycles), 64'd0);
        tick();
        check("mrst_hold", 64'(ib_count), 64'd0);
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
